// File: rtl/apb_pkg.sv
// Shared definitions for the APB master and its companion register slave:
// FSM state encoding, default bus widths and the register map.
package apb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic [31:0] REG_NUMBER_IN_GROUP = 32'h0;
   localparam logic [31:0] REG_DATE            = 32'h4;
   localparam logic [31:0] REG_SURNAME         = 32'h8;
   localparam logic [31:0] REG_NAME            = 32'hC;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// Four-register zero-wait APB slave; unmapped or misaligned addresses read 0
// and ignore writes.
module apb_slave
   import apb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY
);

   logic [DATA_W-1:0] regs [4];
   logic [1:0]        idx;
   logic              mapped;

   // Exact-match decode so misaligned and out-of-range addresses fall through.
   always_comb begin
      idx    = 2'd0;
      mapped = 1'b1;
      if (PADDR == ADDR_W'(REG_NUMBER_IN_GROUP))  idx = 2'd0;
      else if (PADDR == ADDR_W'(REG_DATE))        idx = 2'd1;
      else if (PADDR == ADDR_W'(REG_SURNAME))     idx = 2'd2;
      else if (PADDR == ADDR_W'(REG_NAME))        idx = 2'd3;
      else                                        mapped = 1'b0;
   end

   assign PREADY = PSEL & PENABLE;
   assign PRDATA = (PSEL && !PWRITE && mapped) ? regs[idx] : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (PSEL && PENABLE && PWRITE && mapped) begin
         regs[idx] <= PWDATA;
      end
   end

endmodule

// File: rtl/apb_master_block.sv
// APB master: IDLE once after reset, then back-to-back SETUP/ACCESS transfers
// built from the request inputs sampled on each edge entering SETUP.
module apb_master_block
   import apb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PWRITE_MASTER,
   input  logic [ADDR_W-1:0] PADDR_MASTER,
   input  logic [DATA_W-1:0] PWDATA_MASTER,
   output logic [DATA_W-1:0] PRDATA_MASTER,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   output apb_state_e        fsm_state
);

   apb_state_e state_q;
   apb_state_e state_d;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (PREADY) state_d = SETUP;
         default: state_d = IDLE;
      endcase
   end

   // SETUP is only ever entered, never held, so this marks the request-capture edge.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR  <= '0;
         PWDATA <= '0;
         PWRITE <= 1'b0;
      end else if (state_d == SETUP) begin
         PADDR  <= PADDR_MASTER;
         PWDATA <= PWDATA_MASTER;
         PWRITE <= PWRITE_MASTER;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                                     PRDATA_MASTER <= '0;
      else if (state_q == ACCESS && PREADY && !PWRITE)  PRDATA_MASTER <= PRDATA;
   end

   assign PSEL      = (state_q != IDLE);
   assign PENABLE   = (state_q == ACCESS);
   assign fsm_state = state_q;

endmodule

// File: tb/tb_apb_master_block.sv
// Bench for the APB master wired point to point to the register slave, with a
// stall override on PREADY and a reference model of the register map.
module tb_apb_master_block;
   import apb_pkg::*;

   logic        PCLK;
   logic        PRESETn;
   logic        PWRITE_MASTER;
   logic [31:0] PADDR_MASTER;
   logic [31:0] PWDATA_MASTER;
   logic [31:0] PRDATA_MASTER;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        slave_ready;
   logic        stall;
   apb_state_e  fsm_state;

   logic [31:0] exp_q[$];
   logic [31:0] model_regs[4];
   int          n_vec = 0;
   int          n_err = 0;

   apb_master_block #(.ADDR_W(32), .DATA_W(32)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .PWRITE_MASTER(PWRITE_MASTER), .PADDR_MASTER(PADDR_MASTER),
      .PWDATA_MASTER(PWDATA_MASTER), .PRDATA_MASTER(PRDATA_MASTER),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .fsm_state(fsm_state)
   );

   apb_slave #(.ADDR_W(32), .DATA_W(32)) slave (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(slave_ready)
   );

   assign PREADY = stall ? 1'b0 : slave_ready;

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int model_index(input logic [31:0] a);
      case (a)
         32'h0:   return 0;
         32'h4:   return 1;
         32'h8:   return 2;
         32'hC:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic drive_filler();
      PWRITE_MASTER = 1'b0;
      PADDR_MASTER  = 32'h10;
      PWDATA_MASTER = 32'h0;
   endtask

   // Returns on a negedge where the next rising edge enters SETUP.
   task automatic wait_setup_entry();
      int n = 0;
      @(negedge PCLK);
      while (!(fsm_state == IDLE || (fsm_state == ACCESS && PREADY)) && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      check_eq("sync_bound", 32'(n < 20), 32'd1);
   endtask

   task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int stall_n);
      logic [31:0] old_rd;
      int          idx;
      wait_setup_entry();
      PWRITE_MASTER = w;
      PADDR_MASTER  = a;
      PWDATA_MASTER = d;
      idx = model_index(a);
      if (w) begin
         if (idx >= 0) model_regs[idx] = d;
      end else begin
         exp_q.push_back((idx >= 0) ? model_regs[idx] : 32'h0);
      end
      @(posedge PCLK); #1;
      check_eq("setup_state", 32'(fsm_state), 32'(SETUP));
      check_eq("setup_sel_en", {30'd0, PSEL, PENABLE}, 32'b10);
      check_eq("setup_paddr", PADDR, a);
      check_eq("setup_pwrite", 32'(PWRITE), 32'(w));
      check_eq("setup_pwdata", PWDATA, d);
      old_rd = PRDATA_MASTER;
      // Requests outside the capture edge must have no effect.
      PWRITE_MASTER = 1'($urandom);
      PADDR_MASTER  = $urandom;
      PWDATA_MASTER = $urandom;
      for (int k = 0; k <= stall_n; k++) begin
         @(posedge PCLK); #1;
         check_eq("access_state", 32'(fsm_state), 32'(ACCESS));
         check_eq("access_sel_en", {30'd0, PSEL, PENABLE}, 32'b11);
         check_eq("access_paddr", PADDR, a);
         check_eq("access_pwrite", 32'(PWRITE), 32'(w));
         check_eq("access_pwdata", PWDATA, d);
         check_eq("access_rd_hold", PRDATA_MASTER, old_rd);
         stall = (k < stall_n);
      end
      drive_filler();
      @(posedge PCLK); #1;
      check_eq("end_state", 32'(fsm_state), 32'(SETUP));
      if (!w) check_eq("read_data", PRDATA_MASTER, exp_q.pop_front());
   endtask

   initial begin
      logic [31:0] addrs[6];
      addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h6};
      for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
      stall   = 1'b0;
      PRESETn = 1'b0;
      drive_filler();

      // Reset values, then exactly one IDLE cycle after release
      @(posedge PCLK); #1;
      check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
      check_eq("rst_sel_en", {30'd0, PSEL, PENABLE}, 32'b00);
      check_eq("rst_pwrite", 32'(PWRITE), 32'd0);
      check_eq("rst_paddr", PADDR, 32'h0);
      check_eq("rst_pwdata", PWDATA, 32'h0);
      check_eq("rst_prdata_m", PRDATA_MASTER, 32'h0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      #2;
      check_eq("rel_idle", 32'(fsm_state), 32'(IDLE));
      @(posedge PCLK); #1;
      check_eq("rel_setup", 32'(fsm_state), 32'(SETUP));

      // Basic write/read of register 0x0
      do_xfer(1'b1, 32'h0, 32'd13, 0);
      do_xfer(1'b0, 32'h0, 32'h0, 0);

      // Remaining registers, read back in order
      do_xfer(1'b1, 32'h4, 32'h18122023, 0);
      do_xfer(1'b1, 32'h8, 32'h91A0E9A8, 0);
      do_xfer(1'b1, 32'hC, 32'h80E0E2F1, 0);
      do_xfer(1'b0, 32'h4, 32'h0, 0);
      do_xfer(1'b0, 32'h8, 32'h0, 0);
      do_xfer(1'b0, 32'hC, 32'h0, 0);

      // Unmapped address leaves the map untouched
      do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0);
      do_xfer(1'b0, 32'h10, 32'h0, 0);
      for (int i = 0; i < 4; i++) do_xfer(1'b0, addrs[i], 32'h0, 0);

      // Wait states on write and read
      do_xfer(1'b1, 32'h8, 32'hA5A5_0F0F, 3);
      do_xfer(1'b0, 32'h8, 32'h0, 3);

      // Random mix including misaligned address
      for (int i = 0; i < 10; i++)
         do_xfer(1'($urandom), addrs[$urandom_range(5, 0)], $urandom, $urandom_range(2, 0));

      // Reset during the ACCESS of a write of 0x55 to 0x4
      wait_setup_entry();
      PWRITE_MASTER = 1'b1;
      PADDR_MASTER  = 32'h4;
      PWDATA_MASTER = 32'h55;
      @(posedge PCLK); #1;
      drive_filler();
      @(posedge PCLK); #1;
      check_eq("abort_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
      #2;
      PRESETn = 1'b0;
      #1;
      check_eq("abort_sel_en", {30'd0, PSEL, PENABLE}, 32'b00);
      check_eq("abort_state", 32'(fsm_state), 32'(IDLE));
      check_eq("abort_paddr", PADDR, 32'h0);
      check_eq("abort_prdata_m", PRDATA_MASTER, 32'h0);
      for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      #2;
      check_eq("abort_rel_idle", 32'(fsm_state), 32'(IDLE));
      @(posedge PCLK); #1;
      check_eq("abort_rel_setup", 32'(fsm_state), 32'(SETUP));
      do_xfer(1'b0, 32'h4, 32'h0, 0);
      do_xfer(1'b0, 32'h0, 32'h0, 0);

      check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
